// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache line store.
// Holds the refill FSM state type and helpers that size the address
// fields (offset / index / tag) from the DEPTH and LINE parameters.
package icache_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } refill_state_e;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BYTE_OFF_W = 2;   // cache_addr[1:0] never participates

  // Word-offset field width; kept at least one bit wide so that a
  // one-word line (LINE = 0) still has a legal vector declaration.
  function automatic int off_w(input int line);
    return (line > 0) ? line : 1;
  endfunction

  function automatic int tag_w(input int depth, input int line);
    return ADDR_W - depth - line - BYTE_OFF_W;
  endfunction

  // Mask covering the byte and word offset bits of one line.
  function automatic logic [ADDR_W-1:0] line_mask(input int line);
    return (ADDR_W'(1) << (line + BYTE_OFF_W)) - ADDR_W'(1);
  endfunction

endpackage

// File: rtl/icache_refill.sv
// Refill sequencer for icache_line.
// Detects a miss in IDLE, latches the line base address, then walks the
// 2^LINE beats of the line on the memory port, one beat per accepted
// mem_ready. Also remembers whether a flush was seen during the refill so
// the top level can keep the refilled line invalid.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cache_flush     invalidate-all request (tracked while refilling)
//   cache_valid     fetch request present
//   cache_hit       top-level hit (only meaningful in IDLE)
//   cache_addr      fetch address, latched as line base on a miss
//   mem_ready       current beat accepted
//   mem_valid       registered beat request
//   mem_addr        line base + 4 * beat counter
//   idle            FSM is in IDLE
//   start           IDLE -> REFILL this cycle
//   beat_we         write mem_rdata into the line this cycle
//   last_beat       final beat accepted this cycle
//   flush_pending   a flush arrived earlier in this refill
//   line_base       latched line base address
//   beat_cnt        current beat number
module icache_refill
  import icache_pkg::*;
#(
  parameter int LINE = 2,
  localparam int CNT_W = off_w(LINE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_flush,
  input  logic              cache_valid,
  input  logic              cache_hit,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic              mem_ready,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              idle,
  output logic              start,
  output logic              beat_we,
  output logic              last_beat,
  output logic              flush_pending,
  output logic [ADDR_W-1:0] line_base,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'((1 << LINE) - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~line_mask(LINE);

  refill_state_e     state_reg, state_next;
  logic              mem_valid_reg, mem_valid_next;
  logic              flush_pend_reg, flush_pend_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] base_reg, base_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      mem_valid_reg  <= 1'b0;
      flush_pend_reg <= 1'b0;
      cnt_reg        <= '0;
      base_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      mem_valid_reg  <= mem_valid_next;
      flush_pend_reg <= flush_pend_next;
      cnt_reg        <= cnt_next;
      base_reg       <= base_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    mem_valid_next  = mem_valid_reg;
    flush_pend_next = flush_pend_reg;
    cnt_next        = cnt_reg;
    base_next       = base_reg;
    start           = 1'b0;
    beat_we         = 1'b0;
    last_beat       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // A flush in the same cycle suppresses the refill start.
        if (cache_valid && !cache_hit && !cache_flush) begin
          start           = 1'b1;
          state_next      = ST_REFILL;
          mem_valid_next  = 1'b1;
          flush_pend_next = 1'b0;
          cnt_next        = '0;
          base_next       = cache_addr & BASE_MASK;
        end
      end

      ST_REFILL: begin
        if (cache_flush) begin
          flush_pend_next = 1'b1;
        end
        if (mem_ready) begin
          beat_we = 1'b1;
          if (cnt_reg == LAST_BEAT) begin
            last_beat       = 1'b1;
            state_next      = ST_IDLE;
            mem_valid_next  = 1'b0;
            flush_pend_next = 1'b0;
            cnt_next        = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      default: begin
        state_next     = ST_IDLE;
        mem_valid_next = 1'b0;
      end
    endcase
  end

  assign idle          = (state_reg == ST_IDLE);
  assign mem_valid     = mem_valid_reg;
  assign mem_addr      = base_reg + (ADDR_W'(cnt_reg) << BYTE_OFF_W);
  assign flush_pending = flush_pend_reg;
  assign line_base     = base_reg;
  assign beat_cnt      = cnt_reg;

endmodule

// File: rtl/icache_line.sv
// Direct-mapped instruction cache: 2^DEPTH lines of 2^LINE 32-bit words.
// Hits are combinational in IDLE; a miss triggers a line refill through
// icache_refill, after which the fetch hits on the following cycle.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cache_flush   invalidate all lines on the next edge
//   cache_valid   fetch request present
//   cache_ready   hit: cache_rdata valid this cycle
//   cache_addr    word-aligned fetch address
//   cache_rdata   word at the addressed slot (driven regardless of hit)
//   mem_valid     refill beat request (registered)
//   mem_ready     beat accepted, mem_rdata valid
//   mem_addr      refill beat address
//   mem_rdata     refill beat data
//   stat_hits     (ICACHE_STATS_EN only) cycles with cache_valid && hit
//   stat_misses   (ICACHE_STATS_EN only) refills started
//
// Build option: define ICACHE_STATS_EN to add the hit/miss counters.
module icache_line
  import icache_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int LINE  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_flush,
  input  logic              cache_valid,
  output logic              cache_ready,
  input  logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int LINES   = 1 << DEPTH;
  localparam int WORDS   = 1 << LINE;
  localparam int OFF_W   = off_w(LINE);
  localparam int TAG_W   = tag_w(DEPTH, LINE);
  localparam int DATA_AW = DEPTH + LINE;
  // Zero when LINE = 0, so the padding offset bit never selects.
  localparam logic [OFF_W-1:0] OFF_MASK = OFF_W'(WORDS - 1);

  logic              valid_reg [LINES];
  logic              valid_next [LINES];
  logic [TAG_W-1:0]  tag_mem [LINES];
  logic [DATA_W-1:0] data_mem [LINES * WORDS];

  logic [OFF_W-1:0]   req_offset;
  logic [DEPTH-1:0]   req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [DATA_AW-1:0] rd_addr;

  logic [DEPTH-1:0]   fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic [DATA_AW-1:0] wr_addr;

  logic              idle, start, beat_we, last_beat, flush_pending;
  logic [ADDR_W-1:0] line_base;
  logic [OFF_W-1:0]  beat_cnt;
  logic              hit, set_valid;

  // Request address fields.
  assign req_offset = cache_addr[BYTE_OFF_W +: OFF_W] & OFF_MASK;
  assign req_index  = cache_addr[LINE + BYTE_OFF_W +: DEPTH];
  assign req_tag    = cache_addr[ADDR_W-1 -: TAG_W];
  assign rd_addr    = (DATA_AW'(req_index) << LINE) | DATA_AW'(req_offset);

  // Refill target, taken from the latched line base so that the request
  // address may change freely while the line is being filled.
  assign fill_index = line_base[LINE + BYTE_OFF_W +: DEPTH];
  assign fill_tag   = line_base[ADDR_W-1 -: TAG_W];
  assign wr_addr    = (DATA_AW'(fill_index) << LINE) | DATA_AW'(beat_cnt);

  logic unused_bits;
  assign unused_bits = &{1'b0, cache_addr[BYTE_OFF_W-1:0], line_base[LINE+BYTE_OFF_W-1:0]};

  icache_refill #(
    .LINE(LINE)
  ) u_refill (
    .clk          (clk),
    .rst          (rst),
    .cache_flush  (cache_flush),
    .cache_valid  (cache_valid),
    .cache_hit    (hit),
    .cache_addr   (cache_addr),
    .mem_ready    (mem_ready),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .idle         (idle),
    .start        (start),
    .beat_we      (beat_we),
    .last_beat    (last_beat),
    .flush_pending(flush_pending),
    .line_base    (line_base),
    .beat_cnt     (beat_cnt)
  );

  assign hit         = idle && valid_reg[req_index] && (tag_mem[req_index] == req_tag);
  assign cache_ready = hit;
  assign cache_rdata = data_mem[rd_addr];

  // A flush seen anywhere in the refill, including on the final beat,
  // keeps the freshly filled line invalid.
  assign set_valid = last_beat && !flush_pending && !cache_flush;

  // Per-line valid update: flush beats everything, then the clear on a
  // refill start, then the set on refill completion.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_comb begin
      valid_next[gi] = valid_reg[gi];
      if (cache_flush) begin
        valid_next[gi] = 1'b0;
      end else if (start && (req_index == DEPTH'(gi))) begin
        valid_next[gi] = 1'b0;
      end else if (set_valid && (fill_index == DEPTH'(gi))) begin
        valid_next[gi] = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg[gi] <= 1'b0;
      end else begin
        valid_reg[gi] <= valid_next[gi];
      end
    end
  end

  // Data and tag storage are not reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (beat_we) begin
      data_mem[wr_addr] <= mem_rdata;
    end
    if (last_beat) begin
      tag_mem[fill_index] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits_reg, stat_misses_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits_reg   <= '0;
      stat_misses_reg <= '0;
    end else begin
      if (cache_valid && hit) begin
        stat_hits_reg <= stat_hits_reg + 32'd1;
      end
      if (start) begin
        stat_misses_reg <= stat_misses_reg + 32'd1;
      end
    end
  end

  assign stat_hits   = stat_hits_reg;
  assign stat_misses = stat_misses_reg;
`endif

endmodule

// File: tb/tb_icache_line.sv
// Randomised self-checking bench for icache_line. The memory returns a
// fixed hash of the beat address; a per-line valid/tag table predicts hits,
// and every line refill is checked beat by beat.
module tb_icache_line;

  localparam int DEPTH      = 6;
  localparam int LINE       = 2;
  localparam int WORDS      = 1 << LINE;
  localparam int LINES      = 1 << DEPTH;
  localparam int LINE_BYTES = 4 * WORDS;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_flush;
  logic        cache_valid;
  logic        cache_ready;
  logic [31:0] cache_addr;
  logic [31:0] cache_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state.
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  int unsigned m_hits;
  int unsigned m_misses;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  icache_line #(
    .DEPTH(DEPTH),
    .LINE (LINE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cache_flush(cache_flush),
    .cache_valid(cache_valid),
    .cache_ready(cache_ready),
    .cache_addr (cache_addr),
    .cache_rdata(cache_rdata),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int line_idx(input logic [31:0] a);
    return int'((a / 32'(LINE_BYTES)) % 32'(LINES));
  endfunction

  function automatic logic [31:0] line_tag(input logic [31:0] a);
    return a / 32'(LINE_BYTES * LINES);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic check_stats();
`ifdef ICACHE_STATS_EN
    check_eq("stat_hits", stat_hits, m_hits);
    check_eq("stat_misses", stat_misses, m_misses);
`endif
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; cache_flush = 1'b0; cache_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    cache_valid = 1'b0; cache_flush = 1'b1; mem_ready = 1'b0;
    model_clear();
    $display("[TB] flush");
  endtask

  // One fetch: hit check, or a full refill with per-beat checks followed by
  // the hit probe on the cycle after the last beat.
  task automatic fetch(input logic [31:0] addr, input int stall_lo, input int stall_hi,
                       input int flush_beat, input bit wiggle);
    int          idx;
    logic [31:0] tg;
    logic [31:0] base;
    bit          exp_hit;
    bit          flushed;
    int          nst;
    @(posedge clk); #1;
    cache_valid = 1'b1; cache_addr = addr; cache_flush = 1'b0; mem_ready = 1'b0;
    #1;
    idx = line_idx(addr);
    tg = line_tag(addr);
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    check_eq("hit", cache_ready, exp_hit);
    if (exp_hit) begin
      check_eq("hit_rdata", cache_rdata, mem_word(addr));
      check_eq("hit_memvalid", mem_valid, 0);
      m_hits++;
      $display("[TB] fetch %h hit", addr);
    end else begin
      m_misses++;
      m_valid[idx] = 1'b0;
      base = addr - (addr % 32'(LINE_BYTES));
      flushed = 1'b0;
      for (int b = 0; b < WORDS; b++) begin
        nst = $urandom_range(stall_hi, stall_lo);
        for (int s = 0; s <= nst; s++) begin
          @(posedge clk); #1;
          mem_ready = (s == nst);
          cache_flush = (b == flush_beat) && (s == 0);
          if (wiggle) begin
            cache_valid = 1'($urandom);
            cache_addr = $urandom & 32'hFFFF_FFFC;
          end
          #1;
          check_eq("refill_memvalid", mem_valid, 1);
          check_eq("refill_memaddr", mem_addr, base + 32'(4 * b));
          check_eq("refill_ready", cache_ready, 0);
          if (cache_flush) begin
            flushed = 1'b1;
            model_clear();
          end
        end
      end
      @(posedge clk); #1;
      mem_ready = 1'b0; cache_flush = 1'b0; cache_addr = addr;
      if (!flushed) begin
        m_valid[idx] = 1'b1;
        m_tag[idx] = tg;
        m_hits++;
      end
      cache_valid = !flushed;
      #1;
      check_eq("fill_ready", cache_ready, !flushed);
      check_eq("fill_rdata", cache_rdata, mem_word(addr));
      check_eq("fill_memvalid", mem_valid, 0);
      $display("[TB] fetch %h miss, refill base %h flushed=%0d", addr, base, flushed);
    end
  endtask

  // Start a refill, accept two beats, then reset in the middle of it.
  task automatic reset_mid_refill(input logic [31:0] addr);
    logic [31:0] base;
    do_flush();
    base = addr - (addr % 32'(LINE_BYTES));
    @(posedge clk); #1;
    cache_flush = 1'b0; cache_valid = 1'b1; cache_addr = addr; mem_ready = 1'b0;
    #1;
    check_eq("rm_miss", cache_ready, 0);
    m_misses++;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      cache_valid = 1'b0; mem_ready = 1'b1;
      #1;
      check_eq("rm_memaddr", mem_addr, base + 32'(4 * b));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0; cache_addr = addr;
    model_clear();
    m_hits = 0;
    m_misses = 0;
    #1;
    check_eq("rm_memvalid", mem_valid, 0);
    check_eq("rm_ready", cache_ready, 0);
    @(posedge clk); #1;
    #1;
    check_eq("rm_memvalid2", mem_valid, 0);
    check_eq("rm_ready2", cache_ready, 0);
    $display("[TB] reset during refill of %h", addr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1; cache_flush = 1'b0; cache_valid = 1'b0; mem_ready = 1'b0;
    cache_addr = '0;
    apply_reset();

    // Out of reset nothing hits and no refill is requested.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      cache_addr = (k == 0) ? 32'h0 : ($urandom & 32'hFFFF_FFFC);
      #1;
      check_eq("reset_ready", cache_ready, 0);
      check_eq("reset_memvalid", mem_valid, 0);
    end
    check_stats();

    // Cold fetch, then hits on the rest of the line.
    fetch(32'h100, 0, 0, -1, 1'b0);
    fetch(32'h108, 0, 0, -1, 1'b0);
    fetch(32'h104, 0, 0, -1, 1'b0);
    fetch(32'h10C, 0, 0, -1, 1'b0);
    check_stats();

    // Conflict on the same index with a different tag.
    fetch(32'h1100, 0, 0, -1, 1'b0);
    fetch(32'h100, 0, 0, -1, 1'b0);

    // Flush on the second beat; line must stay invalid.
    fetch(32'h200, 0, 0, 1, 1'b0);
    fetch(32'h200, 0, 0, -1, 1'b0);

    // Three stall cycles per beat.
    fetch(32'h300, 3, 3, -1, 1'b0);
    fetch(32'h30C, 0, 0, -1, 1'b0);

    // Flush coincident with the final beat.
    fetch(32'h400, 0, 0, WORDS - 1, 1'b0);
    fetch(32'h404, 0, 0, -1, 1'b0);

    // Request address and valid changing during the refill.
    fetch(32'h500, 0, 2, -1, 1'b1);

    reset_mid_refill(32'h600);
    check_stats();

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(15, 0) == 0) begin
        do_flush();
      end
      a = 32'($urandom_range(3, 0)) * 32'(LINE_BYTES * LINES)
        + 32'($urandom_range(7, 0)) * 32'(LINE_BYTES)
        + 32'($urandom_range(WORDS - 1, 0)) * 32'd4;
      fetch(a, 0, $urandom_range(2, 0),
            ($urandom_range(9, 0) == 0) ? int'($urandom_range(WORDS - 1, 0)) : -1,
            1'($urandom));
    end
    check_stats();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/icache_line.md
ICACHE_LINE -- requirements
Module: icache_line

Interface
REQ-001 SHALL have parameter DEPTH, default 6, log2 of number of cache lines.
REQ-002 SHALL have parameter LINE, default 2, log2 of 32-bit words per line; legal range 0..4.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cache_flush  input  1  invalidate all lines.
REQ-006 SHALL have port cache_valid  input  1  fetch request present.
REQ-007 SHALL have port cache_ready  output  1  hit; cache_rdata valid this cycle.
REQ-008 SHALL have port cache_addr  input  32  word-aligned fetch address.
REQ-009 SHALL have port cache_rdata  output  32  fetched word.
REQ-010 SHALL have port mem_valid  output  1  refill beat request, registered.
REQ-011 SHALL have port mem_ready  input  1  beat accepted, mem_rdata valid.
REQ-012 SHALL have port mem_addr  output  32  refill beat address.
REQ-013 SHALL have port mem_rdata  input  32  refill beat data.

Function
REQ-014 SHALL split cache_addr: offset [LINE+1:2], index [DEPTH+LINE+1:LINE+2], tag [31:DEPTH+LINE+2]; bits [1:0] ignored.
REQ-015 SHALL store per line: one valid bit, one tag, 2^LINE data words.
REQ-016 SHALL drive cache_ready combinationally = state IDLE && valid[index] && stored tag == addr tag.
REQ-017 SHALL drive cache_rdata = data[index][offset] irrespective of hit.
REQ-018 SHALL implement FSM states IDLE and REFILL.
REQ-019 IDLE -> REFILL when cache_valid && !cache_ready && !cache_flush: latch line base (offset zeroed), index, tag; clear valid[index]; beat counter = 0.
REQ-020 In REFILL SHALL assert mem_valid and drive mem_addr = line base + 4*counter.
REQ-021 On each REFILL cycle with mem_ready SHALL write mem_rdata into data[latched index][counter] and increment counter.
REQ-022 On mem_ready with counter == 2^LINE-1 SHALL write latched tag, set valid (unless REQ-024), deassert mem_valid, return to IDLE.
REQ-023 Miss-to-hit latency SHALL be 1 cycle + 2^LINE accepted beats; hit returned the cycle after last beat.
REQ-024 cache_flush SHALL clear all valid bits next edge; flush during REFILL SHALL let refill complete but leave that line invalid; flush coincident with final beat: flush wins.
REQ-025 Refill SHALL complete even if cache_valid drops or cache_addr changes mid-refill; cache_ready SHALL be 0 throughout REFILL.
REQ-026 mem_valid SHALL stay asserted and mem_addr stable until mem_ready.

Reset
REQ-027 rst SHALL force IDLE, mem_valid=0, counter=0, all valid bits 0, flush-pending 0; data/tag arrays not reset.
REQ-028 rst mid-refill SHALL abandon refill; no line becomes valid.
REQ-029 Out of reset cache_ready SHALL be 0 for every address.

Configuration
REQ-030 Macro ICACHE_STATS_EN, when defined, SHALL add outputs stat_hits[31:0] and stat_misses[31:0].
REQ-031 stat_hits SHALL increment each cycle cache_valid && cache_ready; stat_misses each IDLE->REFILL transition; both wrap; both cleared by rst only.
REQ-032 Without ICACHE_STATS_EN ports and counters SHALL be absent; behaviour otherwise identical.

Structure
REQ-033 Package icache_pkg SHALL hold the FSM state enum and address-field width helper constants.
REQ-034 Refill FSM and beat counter SHALL be one sub-module icache_refill; arrays and hit logic stay in top.

Verification
REQ-035 Cold fetch 0x100, mem_ready always 1 -> mem_addr 0x100,0x104,0x108,0x10C over 4 cycles; cache_ready at 0x100 cycle 6; rdata = beat 0.
REQ-036 After REQ-035, fetch 0x108 -> cache_ready same cycle, rdata = beat 2, mem_valid stays 0.
REQ-037 Fetch 0x100 then 0x1100 (same index, other tag) -> miss, refill 0x1100..0x110C; 0x100 then misses.
REQ-038 Flush asserted on 2nd beat of refill 0x200 -> refill completes 4 beats, next 0x200 fetch misses again.
REQ-039 mem_ready stalled 3 cycles per beat -> mem_addr held, 4 beats total, correct data; rst mid-refill -> mem_valid 0 next cycle, no hit.
REQ-040 With ICACHE_STATS_EN: REQ-035 then 3 hits -> stat_misses=1, stat_hits=4.
